// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register-file write arbiter: ALU priority, long-latency FIFO, pending scoreboard
// Optional WB_FIFO_BYPASS_EN: an empty FIFO with an idle ALU hands an accepted beat straight to rf_*.
module wb_write_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int XLEN       = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [4:0]                    mem_rd,
    input  logic [XLEN-1:0]               mem_data,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
    input  logic [4:0]                    rs1_addr,
    input  logic [4:0]                    rs2_addr,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic                          rf_we,
    output logic [4:0]                    rf_rd,
    output logic [XLEN-1:0]               rf_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [4:0]      r_rd_q   [FIFO_DEPTH];
    logic [XLEN-1:0] r_data_q [FIFO_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_pend;
    logic            r_rf_we;
    logic [4:0]      r_rf_rd;
    logic [XLEN-1:0] r_rf_data;

    logic            w_empty;
    logic            w_full;
    logic            w_accept;
    logic            w_pop;
    logic            w_push;
    logic            w_bypass;
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_data;
    logic            w_sel_valid;
    logic            w_sel_fifo;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic            w_write;
    logic [31:0]     w_pend_next;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == DEPTH_C);
    // Credit is occupancy-only: a same-cycle pop never opens a slot for the incoming beat.
    assign mem_ready   = rst_n & ~w_full;
    assign w_accept    = mem_valid & mem_ready;
    assign w_pop       = ~alu_valid & ~w_empty;
    assign w_head_rd   = r_rd_q[r_rptr];
    assign w_head_data = r_data_q[r_rptr];

`ifdef WB_FIFO_BYPASS_EN
    assign w_bypass = w_accept & w_empty & ~alu_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_accept & ~w_bypass;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_fifo  = 1'b0;
        w_sel_rd    = 5'd0;
        w_sel_data  = '0;
        if (alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = alu_rd;
            w_sel_data  = alu_data;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel_fifo  = 1'b1;
            w_sel_rd    = w_head_rd;
            w_sel_data  = w_head_data;
        end else if (w_bypass) begin
            w_sel_valid = 1'b1;
            w_sel_fifo  = 1'b1;
            w_sel_rd    = mem_rd;
            w_sel_data  = mem_data;
        end
    end

    // x0 writes are consumed from their source but never reach the register file.
    assign w_write = w_sel_valid & (w_sel_rd != 5'd0);

    always_comb begin
        w_pend_next = r_pend;
        if (w_write && w_sel_fifo) begin
            w_pend_next[w_sel_rd] = 1'b0;
        end
        // A new issue to the same rd outranks the retiring write.
        if (issue_valid && (issue_rd != 5'd0)) begin
            w_pend_next[issue_rd] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    assign rs1_busy = (rs1_addr != 5'd0) & r_pend[rs1_addr];
    assign rs2_busy = (rs2_addr != 5'd0) & r_pend[rs2_addr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_q[r_wptr]   <= mem_rd;
            r_data_q[r_wptr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_pend    <= '0;
            r_rf_we   <= 1'b0;
            r_rf_rd   <= 5'd0;
            r_rf_data <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_pend  <= w_pend_next;
            r_rf_we <= w_write;
            if (w_write) begin
                r_rf_rd   <= w_sel_rd;
                r_rf_data <= w_sel_data;
            end
        end
    end

    assign rf_we      = r_rf_we;
    assign rf_rd      = r_rf_rd;
    assign rf_data    = r_rf_data;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - self-checking bench for wb_write_arbiter with a queue-based reference model
module tb_wb_write_arbiter;

    localparam int FIFO_DEPTH = 4;
    localparam int XLEN       = 32;
    localparam int CW         = 3;

    logic            clk;
    logic            rst_n;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_data;
    logic [CW-1:0]   fifo_count;

    int n_cmp;
    int n_fail;

    logic [36:0]     m_q[$];
    logic [31:0]     m_pend;
    logic            m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;

    wb_write_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advances the model from the current inputs, then clocks the DUT and settles past the edge.
    task automatic tick();
        logic            acc;
        logic            sv;
        logic            fsrc;
        logic            byp;
        logic [4:0]      srd;
        logic [XLEN-1:0] sdat;
        logic [36:0]     e;
        if (!rst_n) begin
            m_q.delete();
            m_pend = '0;
            m_we   = 1'b0;
            m_rd   = 5'd0;
            m_data = '0;
        end else begin
            acc  = mem_valid && (m_q.size() < FIFO_DEPTH);
            sv   = 1'b0;
            fsrc = 1'b0;
            byp  = 1'b0;
            srd  = 5'd0;
            sdat = '0;
            if (alu_valid) begin
                sv = 1'b1; srd = alu_rd; sdat = alu_data;
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                sv = 1'b1; fsrc = 1'b1; srd = e[36:32]; sdat = e[31:0];
            end
`ifdef WB_FIFO_BYPASS_EN
            else if (acc) begin
                sv = 1'b1; fsrc = 1'b1; byp = 1'b1; srd = mem_rd; sdat = mem_data;
            end
`endif
            m_we = sv && (srd != 5'd0);
            if (m_we) begin
                m_rd   = srd;
                m_data = sdat;
            end
            if (fsrc && srd != 5'd0) m_pend[srd] = 1'b0;
            if (acc && !byp) m_q.push_back({mem_rd, mem_data});
            if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = '0;
        issue_valid = 1'b0; issue_rd = 5'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        rs1_addr = 5'd3;
        #1;
        n_cmp++;
        if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready actual=%b required=0", mem_ready); end
        tick();
        tick();
        n_cmp++;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we actual=%b required=0", rf_we); end
        n_cmp++;
        if (rf_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rf_rd actual=%0d required=0", rf_rd); end
        n_cmp++;
        if (rf_data !== 32'd0) begin n_fail++; $display("FAIL reset_rf_data actual=%h required=0", rf_data); end
        n_cmp++;
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count actual=%0d required=0", fifo_count); end
        n_cmp++;
        if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b required=0", rs1_busy); end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready actual=%b required=1", mem_ready); end
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        n_cmp++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL alu_write actual=%b/%0d/%h required=1/5/deadbeef", rf_we, rf_rd, rf_data);
        end
        alu_rd = 5'd0; alu_data = 32'h55;
        tick();
        n_cmp++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL alu_x0_hold actual=%b/%0d/%h required=0/5/deadbeef", rf_we, rf_rd, rf_data);
        end
        alu_valid = 1'b0;
    endtask

    task automatic test_pending();
        issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
        tick();
        issue_valid = 1'b0;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL pend_set actual=%b required=1", rs1_busy); end
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234;
        #1;
        n_cmp++;
        if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL pend_ready actual=%b required=1", mem_ready); end
        tick();
        mem_valid = 1'b0;
        #1;
`ifdef WB_FIFO_BYPASS_EN
        n_cmp++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'h1234 || rs1_busy !== 1'b0) begin
            n_fail++; $display("FAIL pend_bypass actual=%b/%0d/%h busy=%b required=1/7/1234 busy=0", rf_we, rf_rd, rf_data, rs1_busy);
        end
`else
        n_cmp++;
        if (rf_we !== 1'b0 || rs1_busy !== 1'b1 || fifo_count !== 3'd1) begin
            n_fail++; $display("FAIL pend_queued actual=we%b busy%b cnt%0d required=we0 busy1 cnt1", rf_we, rs1_busy, fifo_count);
        end
        tick();
        n_cmp++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'h1234 || rs1_busy !== 1'b0) begin
            n_fail++; $display("FAIL pend_drain actual=%b/%0d/%h busy=%b required=1/7/1234 busy=0", rf_we, rf_rd, rf_data, rs1_busy);
        end
`endif
    endtask

    task automatic test_fill();
        int k;
        for (int i = 0; i < 6; i++) begin
            k = (i < 4) ? i : 4;
            alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'hA000 + i;
            mem_valid = 1'b1; mem_rd = 5'(10 + k); mem_data = 32'hB000 + k;
            #1;
            n_cmp++;
            if (mem_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_ready[%0d] actual=%b required=%b", i, mem_ready, (i < 4)); end
            tick();
            n_cmp++;
            if (rf_we !== 1'b1 || rf_rd !== 5'(20 + i) || fifo_count !== 3'((i < 3) ? i + 1 : 4)) begin
                n_fail++; $display("FAIL fill_alu[%0d] actual=%b/%0d cnt%0d", i, rf_we, rf_rd, fifo_count);
            end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            n_cmp++;
            if (rf_we !== 1'b1 || rf_rd !== 5'(10 + j) || rf_data !== 32'hB000 + j) begin
                n_fail++; $display("FAIL fill_drain[%0d] actual=%b/%0d/%h required=1/%0d/%h", j, rf_we, rf_rd, rf_data, 10 + j, 32'hB000 + j);
            end
        end
        tick();
        n_cmp++;
        if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL fill_empty actual=we%b cnt%0d required=we0 cnt0", rf_we, fifo_count); end
    endtask

    task automatic test_same_cycle();
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9; rs1_addr = 5'd9;
        tick();
        issue_valid = 1'b0;
        #1;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_data !== 32'h99) begin
            n_fail++; $display("FAIL same_write actual=%b/%0d/%h required=1/9/99", rf_we, rf_rd, rf_data);
        end
        n_cmp++;
        if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL same_set_wins actual=%b required=1", rs1_busy); end
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_rd = 5'(11 + i); mem_data = 32'hC000 + i;
            issue_valid = (i < 2); issue_rd = 5'(3 + i);
            tick();
        end
        idle_inputs();
        rs1_addr = 5'd3; rs2_addr = 5'd4;
        #1;
        n_cmp++;
        if (fifo_count !== 3'd3 || rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup actual=cnt%0d busy%b%b required=cnt3 busy11", fifo_count, rs1_busy, rs2_busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_low actual=%b required=0", mem_ready); end
        tick();
        n_cmp++;
        if (rf_we !== 1'b0 || fifo_count !== 3'd0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset actual=we%b cnt%0d busy%b%b rdy%b required=we0 cnt0 busy00 rdy0", rf_we, fifo_count, rs1_busy, rs2_busy, mem_ready);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_high actual=%b required=1", mem_ready); end
        tick();
        n_cmp++;
        if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_no_write actual=we%b cnt%0d required=we0 cnt0", rf_we, fifo_count); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n       = ($urandom_range(0, 63) != 0);
            alu_valid   = ($urandom_range(0, 99) < 40);
            alu_rd      = 5'($urandom_range(0, 7));
            alu_data    = $urandom;
            mem_valid   = ($urandom_range(0, 99) < 55);
            mem_rd      = 5'($urandom_range(0, 7));
            mem_data    = $urandom;
            issue_valid = ($urandom_range(0, 99) < 30);
            issue_rd    = 5'($urandom_range(0, 7));
            rs1_addr    = 5'($urandom_range(0, 7));
            rs2_addr    = 5'($urandom_range(0, 7));
            #1;
            n_cmp++;
            if (mem_ready !== (rst_n && m_q.size() < FIFO_DEPTH) ||
                rs1_busy !== (rs1_addr != 5'd0 && m_pend[rs1_addr]) ||
                rs2_busy !== (rs2_addr != 5'd0 && m_pend[rs2_addr])) begin
                n_fail++; $display("FAIL rnd_comb[%0d] actual=rdy%b b%b%b required=rdy%b b%b%b", c, mem_ready, rs1_busy, rs2_busy,
                                   (rst_n && m_q.size() < FIFO_DEPTH), (rs1_addr != 5'd0 && m_pend[rs1_addr]), (rs2_addr != 5'd0 && m_pend[rs2_addr]));
            end
            tick();
            n_cmp++;
            if (rf_we !== m_we || rf_rd !== m_rd || rf_data !== m_data || fifo_count !== CW'(m_q.size())) begin
                n_fail++; $display("FAIL rnd_out[%0d] actual=%b/%0d/%h cnt%0d required=%b/%0d/%h cnt%0d", c, rf_we, rf_rd, rf_data, fifo_count,
                                   m_we, m_rd, m_data, m_q.size());
            end
        end
        idle_inputs();
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        m_pend = '0;
        m_we   = 1'b0;
        m_rd   = 5'd0;
        m_data = '0;
        test_reset();
        test_alu();
        test_pending();
        test_fill();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-side initiator for the pipeline's single-write-port integer register file. It merges in-order ALU results with out-of-order long-latency results (loads, multi-cycle units) into one registered write stream (`rf_we`/`rf_rd`/`rf_data`). It buffers long-latency results in a small FIFO and keeps a per-register pending scoreboard that decode uses to stall on unready operands. It sits between the writeback stage and the register file write port.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: long-latency result FIFO entries; power of two, at least 2.
- `XLEN`, 32: data width.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: reset. Synchronous and active-low.
- `alu_valid`  in  1: ALU result present this cycle. No backpressure.
- `alu_rd`  in  5: ALU destination register.
- `alu_data`  in  XLEN: ALU result.
- `mem_valid`  in  1: long-latency result offered.
- `mem_ready`  out  1: FIFO can accept; a beat is transferred when `mem_valid & mem_ready`.
- `mem_rd`  in  5: long-latency destination register.
- `mem_data`  in  XLEN: long-latency result.
- `issue_valid`  in  1: a long-latency op issued this cycle; marks `issue_rd` pending.
- `issue_rd`  in  5: destination of the issued op.
- `rs1_addr`, `rs2_addr`  in  5: decode source registers.
- `rs1_busy`, `rs2_busy`  out  1: combinational; the source is pending.
- `rf_we`  out  1: registered register-file write enable.
- `rf_rd`  out  5: registered write address.
- `rf_data`  out  XLEN: registered write data.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Per-cycle write selection, highest priority first:
  - `alu_valid`: drive ALU result.
  - FIFO non-empty: pop the head.
  - Otherwise: no write.
- The ALU path is never stalled. The FIFO drains only in cycles without `alu_valid`.
- x0 handling:
  - Any selected write with rd == 0 is consumed (FIFO popped if applicable) but produces `rf_we=0`.
  - `rs*_busy` for address 0 is always 0.
  - The scoreboard bit for x0 is never set.
- Scoreboard: 32 pending bits.
  - Set on `issue_valid` with `issue_rd != 0`.
  - Cleared when a FIFO-sourced write to that rd is emitted.
  - ALU writes never clear pending bits.
  - If a set and a clear hit the same rd in the same cycle, set wins.
- `rsN_busy = pending[rsN_addr]` (combinational, pre-edge state).
- FIFO:
  - Push on `mem_valid & mem_ready`.
  - `mem_ready = rst_n & (fifo_count < FIFO_DEPTH)`. It depends on occupancy only: a pop in the same cycle does not create a credit.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering: correctness of ALU-vs-FIFO ordering to the same rd relies on decode stalling on `rs*_busy`/pending. The block itself does not reorder or check this.

## Timing
- Reset (`rst_n` low at an edge):
  - `rf_we=0`, `rf_rd=0`, `rf_data=0`.
  - FIFO emptied, `fifo_count=0`.
  - All pending bits cleared.
  - `mem_ready=0` while `rst_n` is low.
- Reset mid-operation discards buffered results and pending bits with no writes emitted.
- ALU latency: `alu_valid` in cycle N gives `rf_we=1` after edge N, visible in cycle N+1.
- Long-latency latency:
  - A beat accepted at edge N is the FIFO head in cycle N+1.
  - Earliest `rf_we` is in cycle N+2. It is delayed one cycle per cycle with `alu_valid` high.
- Pending-bit effects:
  - A pending bit set at edge N asserts busy from cycle N+1.
  - A clear coincides with the edge that loads `rf_we`, so busy drops in the same cycle the write is presented to the register file.
- `rf_*` hold their last `rf_rd`/`rf_data` when `rf_we=0`. Only `rf_we` deasserts.

## Configuration
- `WB_FIFO_BYPASS_EN`, when defined:
  - If the FIFO is empty, `alu_valid=0` and a beat is accepted, the beat goes directly to `rf_*` at that edge (1-cycle latency). It is not pushed, and its pending bit clears at the same edge.
- When not defined:
  - All long-latency beats pass through the FIFO (minimum 2-cycle latency).

## Test plan
- Reset, then `alu_valid=1`, `alu_rd=5`, `alu_data=0xDEADBEEF` -> next cycle `rf_we=1`, `rf_rd=5`, `rf_data=0xDEADBEEF`. With `alu_rd=0` -> `rf_we=0`.
- `issue_valid`, `issue_rd=7`; `rs1_addr=7` -> `rs1_busy=1` next cycle. Later accept mem beat rd=7, data 0x1234 with no ALU activity -> `rf_we` with rd=7, 0x1234 two cycles after acceptance (one with bypass), and `rs1_busy=0` in that cycle.
- Fill FIFO with 4 beats while `alu_valid` is held high for 6 cycles -> `mem_ready=0` at count 4, no FIFO writes emitted. After ALU stops, 4 writes are emitted in push order on consecutive cycles.
- Same-cycle `issue_valid` rd=9 and FIFO pop of rd=9 -> rd=9 written, pending[9] remains 1.
- Assert `rst_n=0` with 3 entries buffered and 2 pending bits -> `rf_we=0`, `fifo_count=0`, all busy 0, `mem_ready=0` during reset, then 1.
